// File: rtl/raiden_pkg.sv
// Shared Raiden game-core definitions: player column limits, default bullet
// geometry, slot-state encoding and the player-column clamp helper.
package raiden_pkg;

  // Legal player columns; out-of-range columns are clamped to this window.
  localparam int unsigned POS_MIN = 1;
  localparam int unsigned POS_MAX = 6;

  // Width of a column index.
  localparam int unsigned COL_W = 3;

  // Default bullet-field geometry.
  localparam int unsigned NUM_BULLETS_DEF = 4;
  localparam int unsigned ROWS_DEF        = 8;
  localparam int unsigned ROW_W_DEF       = 3;

  // Per-slot state.
  typedef enum logic {
    SlotFree = 1'b0,
    SlotLive = 1'b1
  } slot_state_e;

  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] pos);
    if (pos < COL_W'(POS_MIN)) return COL_W'(POS_MIN);
    if (pos > COL_W'(POS_MAX)) return COL_W'(POS_MAX);
    return pos;
  endfunction

endpackage

// File: rtl/bullet_ctrl_if.sv
// Bullet controller bus: fire requests from the keypad scanner in, slot state
// and handshake pulses out to display/collision logic.
//   fire         keypad fire level (rising edge = request)
//   playPos      player column
//   bullet_valid per-slot live flag
//   bullet_col   packed slot columns, slot i at [3i+2:3i]
//   bullet_row   packed slot rows, slot i at [ROW_W*i +: ROW_W]
//   fire_ack     request accepted into a slot (one cycle)
//   fire_drop    request discarded (one cycle)
//   tick         game-tick strobe
// modport master: keypad/game side; modport slave: bullet_ctrl.
interface bullet_ctrl_if
  import raiden_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int unsigned ROW_W       = ROW_W_DEF
) ();

  logic                         fire;
  logic [COL_W-1:0]             playPos;
  logic [NUM_BULLETS-1:0]       bullet_valid;
  logic [COL_W*NUM_BULLETS-1:0] bullet_col;
  logic [ROW_W*NUM_BULLETS-1:0] bullet_row;
  logic                         fire_ack;
  logic                         fire_drop;
  logic                         tick;

  modport master (
    output fire,
    output playPos,
    input  bullet_valid,
    input  bullet_col,
    input  bullet_row,
    input  fire_ack,
    input  fire_drop,
    input  tick
  );

  modport slave (
    input  fire,
    input  playPos,
    output bullet_valid,
    output bullet_col,
    output bullet_row,
    output fire_ack,
    output fire_drop,
    output tick
  );

endinterface

// File: rtl/bullet_ctrl_tick_gen.sv
// Game-tick prescaler shared by the game blocks. Counts 0..TICK_DIV-1 and
// raises tick for exactly one cycle per wrap; the first tick is visible
// TICK_DIV cycles after reset release.
//   clk   system clock
//   rst   asynchronous active-low reset
//   tick  one-cycle game-tick strobe
module tick_gen #(
  parameter int unsigned TICK_DIV = 4194304
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet slot owner for the Raiden core. Allocates the lowest free slot
// at the (clamped) player column on each fire rising edge, moves live bullets
// up one row per game tick and frees bullets that leave row 0.
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  bullet_ctrl_if.slave (fire/playPos in; slot state, fire_ack,
//        fire_drop, tick out)
// Optional: define BULLET_COOLDOWN_EN to enforce COOLDOWN ticks between
// accepted shots.
module bullet_ctrl
  import raiden_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int unsigned ROWS        = ROWS_DEF,
  parameter int unsigned ROW_W       = ROW_W_DEF,
  parameter int unsigned TICK_DIV    = 4194304
`ifdef BULLET_COOLDOWN_EN
  ,
  parameter int unsigned COOLDOWN    = 2
`endif
) (
  input logic          clk,
  input logic          rst,
  bullet_ctrl_if.slave bus
);

  localparam logic [ROW_W-1:0] RowSpawn = ROW_W'(ROWS - 1);

  logic                   tick;
  logic                   fire_d_q;
  logic                   req;
  logic [COL_W-1:0]       spawn_col;
  logic [NUM_BULLETS-1:0] grant;
  logic                   slot_free;
  logic                   cd_block;
  logic                   accept;
  logic                   drop;
  logic                   ack_q;
  logic                   drop_q;

  slot_state_e      state_q [NUM_BULLETS];
  slot_state_e      state_d [NUM_BULLETS];
  logic [ROW_W-1:0] row_q   [NUM_BULLETS];
  logic [ROW_W-1:0] row_d   [NUM_BULLETS];
  logic [COL_W-1:0] col_q   [NUM_BULLETS];
  logic [COL_W-1:0] col_d   [NUM_BULLETS];

  logic [NUM_BULLETS-1:0]       valid_vec;
  logic [COL_W*NUM_BULLETS-1:0] col_vec;
  logic [ROW_W*NUM_BULLETS-1:0] row_vec;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign req       = bus.fire & ~fire_d_q;
  assign spawn_col = clamp_col(bus.playPos);

  // Free slots are judged on pre-edge state, so a slot freed by this tick is
  // not offered to a request in the same cycle.
  always_comb begin
    grant     = '0;
    slot_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_free && state_q[i] == SlotFree) begin
        grant[i]  = 1'b1;
        slot_free = 1'b1;
      end
    end
  end

`ifdef BULLET_COOLDOWN_EN
  localparam int unsigned CdW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [CdW-1:0] cd_q, cd_d;

  // Blocking uses the pre-decrement count when a tick coincides.
  assign cd_block = (cd_q != '0);

  always_comb begin
    cd_d = cd_q;
    if (accept) begin
      cd_d = CdW'(COOLDOWN);
    end else if (tick && cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end
`else
  assign cd_block = 1'b0;
`endif

  assign accept = req & slot_free & ~cd_block;
  assign drop   = req & ~accept;

  // Per-slot FSM; a new bullet is written at the spawn row and is not moved
  // by a coincident tick because only LIVE slots move.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      state_d[i] = state_q[i];
      row_d[i]   = row_q[i];
      col_d[i]   = col_q[i];
      unique case (state_q[i])
        SlotFree: begin
          if (accept && grant[i]) begin
            state_d[i] = SlotLive;
            row_d[i]   = RowSpawn;
            col_d[i]   = spawn_col;
          end
        end
        SlotLive: begin
          if (tick) begin
            // Leaving the top frees the slot; row/col are left as they were.
            if (row_q[i] == '0) begin
              state_d[i] = SlotFree;
            end else begin
              row_d[i] = row_q[i] - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_d_q <= 1'b0;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        state_q[i] <= SlotFree;
        row_q[i]   <= '0;
        col_q[i]   <= '0;
      end
    end else begin
      fire_d_q <= bus.fire;
      ack_q    <= accept;
      drop_q   <= drop;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        state_q[i] <= state_d[i];
        row_q[i]   <= row_d[i];
        col_q[i]   <= col_d[i];
      end
    end
  end

  always_comb begin
    valid_vec = '0;
    col_vec   = '0;
    row_vec   = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      valid_vec[i]               = (state_q[i] == SlotLive);
      col_vec[COL_W*i +: COL_W]  = col_q[i];
      row_vec[ROW_W*i +: ROW_W]  = row_q[i];
    end
  end

  assign bus.bullet_valid = valid_vec;
  assign bus.bullet_col   = col_vec;
  assign bus.bullet_row   = row_vec;
  assign bus.fire_ack     = ack_q;
  assign bus.fire_drop    = drop_q;
  assign bus.tick         = tick;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl with a slot-list reference model.
module tb_bullet_ctrl;

  localparam int NB       = 4;
  localparam int ROWS     = 8;
  localparam int ROW_W    = 3;
  localparam int TICK_DIV = 4;
`ifdef BULLET_COOLDOWN_EN
  localparam int COOLDOWN = 2;
`endif
  localparam int SW = NB + 3 * NB + ROW_W * NB + 3;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  bullet_ctrl_if #(.NUM_BULLETS(NB), .ROW_W(ROW_W)) bus ();

  bullet_ctrl #(
    .NUM_BULLETS(NB),
    .ROWS       (ROWS),
    .ROW_W      (ROW_W),
    .TICK_DIV   (TICK_DIV)
`ifdef BULLET_COOLDOWN_EN
    ,
    .COOLDOWN   (COOLDOWN)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a list of bullets with integer rows/columns.
  bit m_valid [NB];
  int m_row   [NB];
  int m_col   [NB];
  bit m_ack, m_drop, m_tick, m_fire_d;
  int m_edges;
  int m_cd;

  always @(posedge clk or negedge rst) begin : model
    bit nv [NB];
    int nr [NB];
    int slot, p, ncd;
    bit req, acc;
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        m_valid[i] <= 1'b0;
        m_row[i]   <= 0;
        m_col[i]   <= 0;
      end
      m_ack <= 1'b0; m_drop <= 1'b0; m_tick <= 1'b0; m_fire_d <= 1'b0;
      m_edges <= 0; m_cd <= 0;
    end else begin
      req  = bus.fire && !m_fire_d;
      slot = -1;
      for (int i = 0; i < NB; i++) begin
        nv[i] = m_valid[i];
        nr[i] = m_row[i];
        if (!m_valid[i] && slot < 0) slot = i;
      end
      if (m_tick) begin
        for (int i = 0; i < NB; i++) begin
          if (m_valid[i]) begin
            if (m_row[i] == 0) nv[i] = 1'b0;
            else nr[i] = m_row[i] - 1;
          end
        end
      end
      acc = req && (slot >= 0);
      ncd = m_cd;
`ifdef BULLET_COOLDOWN_EN
      if (m_cd != 0) acc = 1'b0;
      if (acc) ncd = COOLDOWN;
      else if (m_tick && m_cd > 0) ncd = m_cd - 1;
`endif
      if (acc) begin
        p = int'(bus.playPos);
        nv[slot] = 1'b1;
        nr[slot] = ROWS - 1;
        m_col[slot] <= (p < 1) ? 1 : ((p > 6) ? 6 : p);
      end
      for (int i = 0; i < NB; i++) begin
        m_valid[i] <= nv[i];
        m_row[i]   <= nr[i];
      end
      m_ack    <= acc;
      m_drop   <= req && !acc;
      m_cd     <= ncd;
      m_fire_d <= bus.fire;
      m_edges  <= m_edges + 1;
      m_tick   <= ((m_edges + 1) % TICK_DIV) == 0;
    end
  end

  logic [SW-1:0] obs;
  assign obs = {bus.bullet_valid, bus.bullet_col, bus.bullet_row,
                bus.fire_ack, bus.fire_drop, bus.tick};

  function automatic logic [SW-1:0] exp_state();
    logic [NB-1:0]       v;
    logic [3*NB-1:0]     c;
    logic [ROW_W*NB-1:0] r;
    for (int i = 0; i < NB; i++) begin
      v[i]                  = m_valid[i];
      c[3*i +: 3]           = 3'(m_col[i]);
      r[ROW_W*i +: ROW_W]   = ROW_W'(m_row[i]);
    end
    return {v, c, r, m_ack, m_drop, m_tick};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    bus.fire = 1'b0;
    bus.playPos = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.fire = 1'b0;
    bus.playPos = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) $display("FAIL reset_zero: got %h want 0", obs);
    else passed++;
    checks++;
    if (obs !== exp_state()) $display("FAIL reset_model: got %h want %h", obs, exp_state());
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_single_shot();
    int ticks;
    bit freed;
    reset_dut();
    bus.playPos = 3'd3;
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.bullet_valid[0], bus.bullet_col[2:0], bus.bullet_row[2:0], bus.fire_ack}
        !== {1'b1, 3'd3, 3'd7, 1'b1})
      $display("FAIL single_spawn: got v=%b c=%0d r=%0d ack=%b want v=1 c=3 r=7 ack=1",
               bus.bullet_valid[0], bus.bullet_col[2:0], bus.bullet_row[2:0], bus.fire_ack);
    else passed++;
    bus.fire = 1'b0;
    ticks = 0;
    freed = 1'b0;
    for (int c = 0; c < 60 && !freed; c++) begin
      checks++;
      if (obs !== exp_state()) $display("FAIL single_model: got %h want %h", obs, exp_state());
      else passed++;
      if (!bus.bullet_valid[0]) freed = 1'b1;
      else begin
        if (bus.tick) ticks++;
        @(negedge clk);
      end
    end
    checks++;
    if (!freed || ticks != 8)
      $display("FAIL single_lifetime: got freed=%b ticks=%0d want freed=1 ticks=8", freed, ticks);
    else passed++;
  endtask

  task automatic test_full_drop();
    reset_dut();
    for (int k = 0; k < NB; k++) begin
      bus.playPos = 3'(k + 1);
      bus.fire = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.fire_ack !== 1'b1 || obs !== exp_state())
        $display("FAIL fill_ack%0d: got ack=%b st=%h want ack=1 st=%h",
                 k, bus.fire_ack, obs, exp_state());
      else passed++;
      bus.fire = 1'b0;
      @(negedge clk);
    end
    bus.playPos = 3'd5;
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fire_drop, bus.fire_ack, bus.bullet_valid} !== {1'b1, 1'b0, 4'hF})
      $display("FAIL full_drop: got drop=%b ack=%b valid=%b want drop=1 ack=0 valid=1111",
               bus.fire_drop, bus.fire_ack, bus.bullet_valid);
    else passed++;
    checks++;
    if (obs !== exp_state()) $display("FAIL full_model: got %h want %h", obs, exp_state());
    else passed++;
    bus.fire = 1'b0;
  endtask

  // Runs on the full field left by test_full_drop.
  task automatic test_tick_collision();
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3] && m_row[0] == 0 && m_tick)
        hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL collide_setup: got no aligned tick want aligned tick");
    else passed++;
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fire_drop, bus.fire_ack, bus.bullet_valid[0]} !== 3'b100)
      $display("FAIL collide_drop: got drop=%b ack=%b v0=%b want drop=1 ack=0 v0=0",
               bus.fire_drop, bus.fire_ack, bus.bullet_valid[0]);
    else passed++;
    bus.fire = 1'b0;
    @(negedge clk);
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fire_ack, bus.bullet_valid[0], bus.bullet_row[2:0]} !== {1'b1, 1'b1, 3'd7})
      $display("FAIL collide_reuse: got ack=%b v0=%b r0=%0d want ack=1 v0=1 r0=7",
               bus.fire_ack, bus.bullet_valid[0], bus.bullet_row[2:0]);
    else passed++;
    checks++;
    if (obs !== exp_state()) $display("FAIL collide_model: got %h want %h", obs, exp_state());
    else passed++;
    bus.fire = 1'b0;
  endtask

  task automatic test_clamp();
    reset_dut();
    bus.playPos = 3'd0;
    bus.fire = 1'b1;
    @(negedge clk);
    bus.fire = 1'b0;
    @(negedge clk);
    bus.playPos = 3'd7;
    bus.fire = 1'b1;
    @(negedge clk);
    bus.fire = 1'b0;
    checks++;
    if (bus.bullet_col[5:0] !== {3'd6, 3'd1})
      $display("FAIL clamp_cols: got c1=%0d c0=%0d want c1=6 c0=1",
               bus.bullet_col[5:3], bus.bullet_col[2:0]);
    else passed++;
  endtask

  task automatic test_held_fire();
    int acks, drops;
    reset_dut();
    bus.playPos = 3'd4;
    bus.fire = 1'b1;
    acks = 0;
    drops = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.fire_ack) acks++;
      if (bus.fire_drop) drops++;
    end
    bus.fire = 1'b0;
    checks++;
    if (acks != 1 || drops != 0)
      $display("FAIL held_fire: got acks=%0d drops=%0d want acks=1 drops=0", acks, drops);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    int n;
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      bus.playPos = 3'(k + 2);
      bus.fire = 1'b1;
      @(negedge clk);
      bus.fire = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bus.bullet_valid !== 4'b0111)
      $display("FAIL midflight_live: got %b want 0111", bus.bullet_valid);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== '0) $display("FAIL midflight_async: got %h want 0", obs);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 3 * TICK_DIV; c++) begin
      @(negedge clk);
      n++;
      if (bus.tick) break;
    end
    checks++;
    if (n != TICK_DIV) $display("FAIL first_tick: got %0d cycles want %0d", n, TICK_DIV);
    else passed++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      bus.fire = ($urandom_range(0, 99) < 45);
      bus.playPos = 3'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (obs !== exp_state()) $display("FAIL random_c%0d: got %h want %h", c, obs, exp_state());
      else passed++;
    end
    bus.fire = 1'b0;
  endtask

`ifdef BULLET_COOLDOWN_EN
  task automatic test_cooldown();
    int ticks;
    reset_dut();
    bus.playPos = 3'd2;
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fire_ack !== 1'b1) $display("FAIL cd_first: got ack=%b want 1", bus.fire_ack);
    else passed++;
    ticks = int'(bus.tick);
    bus.fire = 1'b0;
    @(negedge clk);
    ticks += int'(bus.tick);
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fire_drop, bus.fire_ack} !== 2'b10)
      $display("FAIL cd_block: got drop=%b ack=%b want drop=1 ack=0", bus.fire_drop, bus.fire_ack);
    else passed++;
    ticks += int'(bus.tick);
    bus.fire = 1'b0;
    for (int c = 0; c < 4 * TICK_DIV && ticks < 2; c++) begin
      @(negedge clk);
      ticks += int'(bus.tick);
    end
    @(negedge clk);
    bus.fire = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fire_ack !== 1'b1) $display("FAIL cd_release: got ack=%b want 1", bus.fire_ack);
    else passed++;
    bus.fire = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0;
    bus.fire = 1'b0;
    bus.playPos = '0;
    test_reset();
    test_single_shot();
    test_full_drop();
    test_tick_collision();
    test_clamp();
    test_held_fire();
    test_reset_midflight();
    test_random();
`ifdef BULLET_COOLDOWN_EN
    test_cooldown();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
